// File: rtl/vld_burst_gen_pkg.sv
// Shared types and defaults for the valid-burst generator.
package vld_burst_gen_pkg;
  localparam int DEF_DATA_WIDTH = 256;
  localparam int DEF_CNT_WIDTH  = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } state_e;
endpackage

// File: rtl/vld_burst_gen_cnt2d_wrap.sv
// Row/column beat counter: column advances on en, wraps into the row count.
import vld_burst_gen_pkg::*;

module cnt2d_wrap #(
  parameter int CNT_WIDTH = DEF_CNT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 clr,
  input  logic [CNT_WIDTH-1:0] rows,
  input  logic [CNT_WIDTH-1:0] cols,
  output logic [CNT_WIDTH-1:0] row,
  output logic [CNT_WIDTH-1:0] col,
  output logic                 col_wrap,
  output logic                 row_last
);
  assign col_wrap = (col == cols - CNT_WIDTH'(1));
  assign row_last = (row == rows - CNT_WIDTH'(1));

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      row <= '0;
      col <= '0;
    end else if (en) begin
      if (col_wrap) begin
        col <= '0;
        row <= row + CNT_WIDTH'(1);
      end else begin
        col <= col + CNT_WIDTH'(1);
      end
    end
  end
endmodule

// File: rtl/vld_burst_gen.sv
// Issues rows*cols per-lane valid beats after a start, honouring stall backpressure.
import vld_burst_gen_pkg::*;

module vld_burst_gen #(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [CNT_WIDTH-1:0]  cfg_rows,
  input  logic [CNT_WIDTH-1:0]  cfg_cols,
  input  logic [DATA_WIDTH-1:0] cfg_lane_mask,
  input  logic                  stall,
  output logic [DATA_WIDTH-1:0] vld_out,
  output logic                  last_out,
  output logic [CNT_WIDTH-1:0]  row_idx,
  output logic [CNT_WIDTH-1:0]  col_idx,
  output logic                  busy,
  output logic                  done
);
  state_e                state;
  logic [CNT_WIDTH-1:0]  rows_q, cols_q;
  logic [DATA_WIDTH-1:0] mask_q;
  logic [CNT_WIDTH-1:0]  row, col;
  logic                  col_wrap, row_last, is_last;
  logic                  accept, issue;

  assign busy    = (state != ST_IDLE);
  assign accept  = (state == ST_IDLE) && start;
  assign issue   = (state == ST_RUN) && !stall;
  assign is_last = col_wrap && row_last;

  cnt2d_wrap #(.CNT_WIDTH(CNT_WIDTH)) u_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (issue),
    .clr      (accept),
    .rows     (rows_q),
    .cols     (cols_q),
    .row      (row),
    .col      (col),
    .col_wrap (col_wrap),
    .row_last (row_last)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      rows_q   <= '0;
      cols_q   <= '0;
      mask_q   <= '0;
      vld_out  <= '0;
      last_out <= 1'b0;
      row_idx  <= '0;
      col_idx  <= '0;
      done     <= 1'b0;
    end else begin
      // Non-beat cycles always present an idle valid vector.
      vld_out  <= '0;
      last_out <= 1'b0;
      done     <= 1'b0;
      case (state)
        ST_IDLE: if (start) begin
          rows_q <= cfg_rows;
          cols_q <= cfg_cols;
          mask_q <= cfg_lane_mask;
          state  <= (cfg_rows != '0 && cfg_cols != '0) ? ST_RUN : ST_FIN;
        end
        ST_RUN: if (!stall) begin
          vld_out  <= mask_q;
          row_idx  <= row;
          col_idx  <= col;
          last_out <= is_last;
          if (is_last) state <= ST_FIN;
        end
        ST_FIN: begin
          done  <= 1'b1;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: doc/vld_burst_gen.md
VLD_BURST_GEN -- requirements
Module: vld_burst_gen

Interface
REQ-001 Parameter DATA_WIDTH, default 256, SHALL set the lane count, i.e. the width of vld_out and cfg_lane_mask.
REQ-002 Parameter CNT_WIDTH, default 16, SHALL set the width of cfg_rows, cfg_cols, row_idx and col_idx.
REQ-003 Block SHALL use one clock; reset is synchronous and active-low.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst_n  input  1  synchronous active-low reset.
REQ-006 start  input  1  launch request; SHALL be honoured only in IDLE.
REQ-007 cfg_rows  input  CNT_WIDTH  row count; SHALL be latched at accepted start.
REQ-008 cfg_cols  input  CNT_WIDTH  column count; SHALL be latched at accepted start.
REQ-009 cfg_lane_mask  input  DATA_WIDTH  active lanes; SHALL be latched at accepted start.
REQ-010 stall  input  1  downstream backpressure; while high, no beat is issued.
REQ-011 vld_out  output  DATA_WIDTH  per-lane valid for the current beat; feeds the downstream valid delay line.
REQ-012 last_out  output  1  marks the final beat of a burst.
REQ-013 row_idx, col_idx  output  CNT_WIDTH each  indices of the beat on vld_out.
REQ-014 busy  output  1  high whenever state is not IDLE.
REQ-015 done  output  1  one-cycle completion pulse.

Function
REQ-016 FSM SHALL have three states: IDLE, RUN, FIN.
- IDLE -> RUN on start when latched rows and cols are both nonzero.
- IDLE -> FIN on start when either latched count is zero.
- RUN -> FIN on an issued last beat.
- FIN -> IDLE unconditionally.
REQ-017 All outputs SHALL be registered, except busy, which SHALL be decoded from the state register.
REQ-018 In a RUN cycle with stall=0, the block SHALL issue one beat on the next cycle:
- vld_out = latched mask;
- row_idx and col_idx = current counters;
- last_out = (row == rows-1 && col == cols-1).
REQ-019 After an issued beat, col SHALL increment; at cols-1, col SHALL wrap to 0 and row SHALL increment.
REQ-020 In a RUN cycle with stall=1, the next-cycle vld_out and last_out SHALL be 0 and the counters SHALL hold.
REQ-021 In every cycle in which no beat is issued, vld_out SHALL be all-zero and last_out SHALL be 0.
REQ-022 Latency: with start sampled high in cycle t and no stall, the first beat SHALL appear in cycle t+2 and busy SHALL be high from t+1.
REQ-023 Last beat visible in cycle k: state SHALL be FIN in cycle k; done=1 and busy=0 SHALL hold in cycle k+1.
REQ-024 Zero-size launch (start in cycle t with rows or cols = 0): no beat SHALL be issued, and done SHALL pulse in cycle t+2.
REQ-025 start while busy SHALL be ignored, and config changes during RUN SHALL have no effect.
REQ-026 A start in the same cycle as done SHALL be accepted.
REQ-027 A burst SHALL contain exactly rows*cols beats, independent of stall pattern.

Reset
REQ-028 rst_n=0 at a clock edge SHALL force the following, including mid-burst:
- state = IDLE;
- counters and latched config = 0;
- vld_out = 0, last_out = 0, done = 0, row_idx = 0, col_idx = 0.
REQ-029 After a mid-burst reset, no stale beat, last_out or done SHALL be emitted.

Structure
REQ-030 The FSM state encodings and the default DATA_WIDTH and CNT_WIDTH SHALL live in the shared CNN defines include.
REQ-031 The row/column counter SHALL be one sub-module, cnt2d_wrap, with enable, clear and wrap-flag outputs.

Verification
REQ-032 rows=2, cols=3, mask=all-ones, no stall -> six beats with col sequence 0,1,2,0,1,2 and row sequence 0,0,0,1,1,1; last_out on beat 6 only; done one cycle later.
REQ-033 rows=1, cols=4, stall high for 2 cycles after beat 2 -> two zero gaps between beats 2 and 3; still exactly 4 beats; last_out on col 3.
REQ-034 rows=0, cols=5 -> vld_out stays 0; done pulses 2 cycles after start; busy is high for 1 cycle.
REQ-035 start re-asserted and cfg_cols changed during a rows=1, cols=3 burst -> burst unaffected; exactly 3 beats; one done.
REQ-036 rst_n low for 1 cycle after beat 2 of a 2x2 burst -> all outputs 0 next cycle; no done; a new start then runs a full 4-beat burst.
REQ-037 mask=0x...0005 (DATA_WIDTH=256), rows=1, cols=1 -> single beat with vld_out=0x...0005 and last_out=1; done next cycle; back-to-back start with done is accepted.
